// File: rtl/sio_pkg.sv
// sio_pkg: shared types and constants for the sio_chan serial channel.
//   tx_state_t / rx_state_t : transmitter and receiver FSM states
//   OVERSAMPLE / MID_SAMPLE : ticks per bit and ticks to mid-start-bit
//   even_parity()           : even-parity bit for up to 8 data bits
// Optional feature macro: SIO_PARITY_EN adds the PARITY states.
package sio_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef SIO_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef SIO_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // Bit that makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sio_fifo.sv
// sio_fifo: synchronous FIFO holding received characters.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : write request and data (dropped when full unless popping)
//   pop, dout    : read request and head-of-queue data
//   full, empty  : occupancy status
module sio_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sio_chan.sv
// sio_chan: asynchronous serial channel (transmitter, 16x oversampling
// receiver, receive FIFO) behind valid/ready character interfaces.
//   clk, reset_n            : clock, asynchronous active-low reset
//   rx / tx                 : serial pins, idle high
//   tx_data/tx_valid/tx_ready, tx_busy : transmit character interface
//   rx_data/rx_valid/rx_ready, rx_active : receive FIFO head and status
//   rx_frame_err, rx_overrun, rx_parity_err : sticky errors, cleared by err_clr
// Optional feature macro: SIO_PARITY_EN (even parity bit after data bits).
module sio_chan
  import sio_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned CLK_DIV    = 326,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_active,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_parity_err,
  input  logic                 err_clr
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  // Free-running oversample tick generator.
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Transmitter. Its divider restarts at the accepting handshake so that
  // every bit, including the start bit, lasts exactly 16*CLK_DIV clocks;
  // counting the shared free-running ticks would shorten the start bit.
  tx_state_t            tx_state;
  logic [DIV_W-1:0]     tx_div;
  logic [3:0]           tx_ph;
  logic [2:0]           tx_bits;
  logic                 tx_stop_cnt;
  logic [DATA_BITS-1:0] tx_sr;
  logic                 tx_bit_end;
`ifdef SIO_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_bit_end = (tx_div == DIV_W'(CLK_DIV - 1)) &&
                      (tx_ph == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state    <= TX_IDLE;
      tx          <= 1'b1;
      tx_ready    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_div      <= '0;
      tx_ph       <= '0;
      tx_bits     <= '0;
      tx_stop_cnt <= '0;
      tx_sr       <= '0;
`ifdef SIO_PARITY_EN
      tx_par      <= 1'b0;
`endif
    end else begin
      if (tx_state != TX_IDLE) begin
        if (tx_div == DIV_W'(CLK_DIV - 1)) begin
          tx_div <= '0;
          tx_ph  <= tx_ph + 4'd1;
        end else begin
          tx_div <= tx_div + 1'b1;
        end
      end
      unique case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_sr    <= tx_data;
`ifdef SIO_PARITY_EN
            tx_par   <= even_parity(8'(tx_data));
`endif
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            tx_div   <= '0;
            tx_ph    <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx       <= tx_sr[0];
            tx_sr    <= tx_sr >> 1;
            tx_bits  <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bits == 3'(DATA_BITS - 1)) begin
`ifdef SIO_PARITY_EN
              tx       <= tx_par;
              tx_state <= TX_PARITY;
`else
              tx       <= 1'b1;
              tx_state <= TX_STOP;
`endif
              tx_stop_cnt <= '0;
            end else begin
              tx      <= tx_sr[0];
              tx_sr   <= tx_sr >> 1;
              tx_bits <= tx_bits + 3'd1;
            end
          end
        end
`ifdef SIO_PARITY_EN
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx       <= 1'b1;
            tx_state <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_stop_cnt == 1'(STOP_BITS - 1)) begin
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              tx_state <= TX_IDLE;
            end else begin
              tx_stop_cnt <= tx_stop_cnt + 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Receiver: 2-flop synchroniser, then mid-bit sampling on shared ticks.
  rx_state_t            rx_state;
  logic                 rx_s1;
  logic                 rx_s2;
  logic [3:0]           rx_ph;
  logic [2:0]           rx_bits;
  logic [DATA_BITS-1:0] rx_sr;
  logic                 rx_sample;
  logic                 push;
  logic                 pop;
  logic                 frame_set;
  logic                 overrun_set;
  logic                 fifo_full;
  logic                 fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // After the start-bit check the phase is zeroed, so phase 15 is mid-bit.
  assign rx_sample = tick && (rx_ph == 4'(OVERSAMPLE - 1));
  assign push      = (rx_state == RX_STOP) && rx_sample && rx_s2;
  assign frame_set = (rx_state == RX_STOP) && rx_sample && !rx_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state  <= RX_IDLE;
      rx_active <= 1'b0;
      rx_ph     <= '0;
      rx_bits   <= '0;
      rx_sr     <= '0;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          if (tick && !rx_s2) begin
            rx_ph     <= '0;
            rx_active <= 1'b1;
            rx_state  <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_ph == 4'(MID_SAMPLE - 1)) begin
              rx_ph <= '0;
              if (rx_s2) begin
                rx_active <= 1'b0;
                rx_state  <= RX_IDLE;
              end else begin
                rx_bits  <= '0;
                rx_state <= RX_DATA;
              end
            end else begin
              rx_ph <= rx_ph + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) rx_ph <= rx_ph + 4'd1;
          if (rx_sample) begin
            rx_sr   <= {rx_s2, rx_sr[DATA_BITS-1:1]};
            rx_bits <= rx_bits + 3'd1;
            if (rx_bits == 3'(DATA_BITS - 1)) begin
`ifdef SIO_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end
          end
        end
`ifdef SIO_PARITY_EN
        RX_PARITY: begin
          if (tick) rx_ph <= rx_ph + 4'd1;
          if (rx_sample) rx_state <= RX_STOP;
        end
`endif
        RX_STOP: begin
          if (tick) rx_ph <= rx_ph + 4'd1;
          if (rx_sample) begin
            rx_active <= 1'b0;
            rx_state  <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  sio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (rx_sr),
    .pop     (pop),
    .dout    (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_valid    = !fifo_empty;
  assign pop         = rx_valid && rx_ready;
  assign overrun_set = push && fifo_full && !pop;

  // Sticky error flags: a set event wins over err_clr in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (frame_set)    rx_frame_err <= 1'b1;
      else if (err_clr) rx_frame_err <= 1'b0;
      if (overrun_set)  rx_overrun   <= 1'b1;
      else if (err_clr) rx_overrun   <= 1'b0;
    end
  end

`ifdef SIO_PARITY_EN
  logic par_set;

  assign par_set = (rx_state == RX_PARITY) && rx_sample &&
                   (rx_s2 != even_parity(8'(rx_sr)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     rx_parity_err <= 1'b0;
    else if (par_set) rx_parity_err <= 1'b1;
    else if (err_clr) rx_parity_err <= 1'b0;
  end
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sio_chan.sv
`timescale 1ns/1ps
module tb_sio_chan;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int BIT_CLK = 16 * CLK_DIV;
`ifdef SIO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_BITS + PAR + STOP_BITS;
  // Start detect -> start check after 8 ticks, then 16 ticks per later bit up to the stop sample.
  localparam int STOP_SAMPLE = CLK_DIV * (8 + 16 * (DATA_BITS + PAR + 1));
  localparam int LAT_MIN = 2 + STOP_SAMPLE + 1;
  localparam int LAT_MAX = LAT_MIN + CLK_DIV - 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_drv;
  logic       loop;
  logic       rx;
  logic       tx;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_active;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_parity_err;
  logic       err_clr;

  int n_vec = 0;
  int n_err = 0;

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  sio_chan #(
    .DATA_BITS  (DATA_BITS),
    .STOP_BITS  (STOP_BITS),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx            (rx),
    .tx            (tx),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_busy       (tx_busy),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_active     (rx_active),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_parity_err (rx_parity_err),
    .err_clr       (err_clr)
  );

  // Reference: level of frame bit k for character d.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DATA_BITS) return d[k-1];
    if (PAR == 1 && k == DATA_BITS + 1) return ^d;
    return 1'b1;
  endfunction

  // Drive one frame onto rx_drv; stop level/length and parity flip are controllable.
  task automatic send_rx_frame(input logic [7:0] d, input logic stop_lvl,
                               input logic flip_par, input int stop_len);
    logic lvl;
    int   len;
    for (int k = 0; k < 1 + DATA_BITS + PAR + 1; k++) begin
      lvl = frame_bit(d, k);
      len = BIT_CLK;
      if (PAR == 1 && k == DATA_BITS + 1) lvl = lvl ^ flip_par;
      if (k == DATA_BITS + PAR + 1) begin
        lvl = stop_lvl;
        len = stop_len;
      end
      rx_drv = lvl;
      repeat (len) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b exp 1", tx); end
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_tx_busy got %b exp 0", tx_busy); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    n_vec++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL reset_rx_active got %b exp 0", rx_active); end
    n_vec++; if ({rx_frame_err, rx_overrun, rx_parity_err} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b exp 000", {rx_frame_err, rx_overrun, rx_parity_err});
    end
  endtask

  task automatic test_tx(input logic [7:0] d);
    int low;
    loop = 1'b0;
    @(negedge clk);
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL tx_ready_before got %b exp 1", tx_ready); end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    low = 0;
    for (int k = 0; k < FRAME_BITS * BIT_CLK; k++) begin
      n_vec++;
      if (tx !== frame_bit(d, k / BIT_CLK)) begin
        n_err++; $display("FAIL tx_bit d=%h cycle %0d got %b exp %b", d, k, tx, frame_bit(d, k / BIT_CLK));
      end
      n_vec++;
      if (tx_busy !== 1'b1) begin n_err++; $display("FAIL tx_busy d=%h cycle %0d got %b exp 1", d, k, tx_busy); end
      if (tx_ready === 1'b0) low++;
      @(negedge clk);
    end
    n_vec++; if (low !== FRAME_BITS * BIT_CLK) begin
      n_err++; $display("FAIL tx_ready_low_len got %0d exp %0d", low, FRAME_BITS * BIT_CLK);
    end
    n_vec++; if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
      n_err++; $display("FAIL tx_end ready/busy/tx got %b%b%b exp 101", tx_ready, tx_busy, tx);
    end
  endtask

  task automatic test_loopback(input logic [7:0] d);
    int   n;
    logic mid_active;
    loop = 1'b1;
    rx_ready = 1'b0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    mid_active = 1'b0;
    while (rx_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == LAT_MIN / 2) mid_active = rx_active;
    end
    n_vec++; if (n < LAT_MIN || n > LAT_MAX) begin
      n_err++; $display("FAIL loop_latency d=%h got %0d exp %0d..%0d", d, n, LAT_MIN, LAT_MAX);
    end
    n_vec++; if (mid_active !== 1'b1) begin n_err++; $display("FAIL loop_rx_active_mid got %b exp 1", mid_active); end
    n_vec++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL loop_rx_active_end got %b exp 0", rx_active); end
    n_vec++; if (rx_data !== d) begin n_err++; $display("FAIL loop_rx_data got %h exp %h", rx_data, d); end
    n_vec++; if ({rx_frame_err, rx_overrun, rx_parity_err} !== 3'b000) begin
      n_err++; $display("FAIL loop_flags got %b exp 000", {rx_frame_err, rx_overrun, rx_parity_err});
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL loop_pop got %b exp 0", rx_valid); end
    n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL loop_tx_done got %b exp 1", tx_ready); end
    loop = 1'b0;
  endtask

  task automatic test_glitch();
    logic seen;
    loop = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    rx_drv = 1'b0;
    for (int c = 0; c < 26 * CLK_DIV; c++) begin
      if (c == 6 * CLK_DIV) rx_drv = 1'b1;
      @(negedge clk);
      if (rx_active === 1'b1) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL glitch_active_pulse got %b exp 1", seen); end
    n_vec++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL glitch_active_end got %b exp 0", rx_active); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL glitch_rx_valid got %b exp 0", rx_valid); end
    n_vec++; if ({rx_frame_err, rx_overrun, rx_parity_err} !== 3'b000) begin
      n_err++; $display("FAIL glitch_flags got %b exp 000", {rx_frame_err, rx_overrun, rx_parity_err});
    end
  endtask

  task automatic test_frame_err();
    logic seen;
    loop = 1'b0;
    rx_ready = 1'b0;
    send_rx_frame(8'($urandom), 1'b0, 1'b0, BIT_CLK * 5 / 8);
    repeat (2 * BIT_CLK) @(negedge clk);
    n_vec++; if (rx_frame_err !== 1'b1) begin n_err++; $display("FAIL frame_err_set got %b exp 1", rx_frame_err); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL frame_err_fifo got %b exp 0", rx_valid); end
    clear_errors();
    n_vec++; if (rx_frame_err !== 1'b0) begin n_err++; $display("FAIL frame_err_clr got %b exp 0", rx_frame_err); end
    // With err_clr held, the set still shows for at least one cycle.
    seen = 1'b0;
    err_clr = 1'b1;
    fork
      send_rx_frame(8'($urandom), 1'b0, 1'b0, BIT_CLK * 5 / 8);
      for (int c = 0; c < (FRAME_BITS + 1) * BIT_CLK; c++) begin
        @(negedge clk);
        if (rx_frame_err === 1'b1) seen = 1'b1;
      end
    join
    err_clr = 1'b0;
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL frame_err_set_wins got %b exp 1", seen); end
    repeat (2 * BIT_CLK) @(negedge clk);
  endtask

  task automatic test_overrun();
    logic [7:0] q[$];
    logic [7:0] d;
    logic       exp_ovr;
    loop = 1'b0;
    rx_ready = 1'b0;
    exp_ovr = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      d = 8'($urandom);
      send_rx_frame(d, 1'b1, 1'b0, BIT_CLK);
      repeat (4) @(negedge clk);
      if (q.size() < FIFO_DEPTH) q.push_back(d);
      else exp_ovr = 1'b1;
    end
    n_vec++; if (rx_overrun !== exp_ovr) begin n_err++; $display("FAIL overrun_flag got %b exp %b", rx_overrun, exp_ovr); end
    n_vec++; if (rx_frame_err !== 1'b0) begin n_err++; $display("FAIL overrun_frame_err got %b exp 0", rx_frame_err); end
    while (q.size() > 0) begin
      d = q.pop_front();
      n_vec++; if (rx_valid !== 1'b1 || rx_data !== d) begin
        n_err++; $display("FAIL overrun_pop valid/data got %b/%h exp 1/%h", rx_valid, rx_data, d);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL overrun_drained got %b exp 0", rx_valid); end
    clear_errors();
    n_vec++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clr got %b exp 0", rx_overrun); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int         got;
    int         sent_n;
    localparam int N = 4;
    loop = 1'b1;
    rx_ready = 1'b1;
    got = 0;
    sent_n = 0;
    fork
      for (int i = 0; i < N; i++) begin
        int w;
        logic [7:0] d;
        d = 8'($urandom);
        w = 0;
        while (tx_ready !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        exp_q.push_back(d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        sent_n++;
      end
      for (int c = 0; c < N * (FRAME_BITS * BIT_CLK + 20) + 400 && got < N; c++) begin
        @(negedge clk);
        if (rx_valid === 1'b1) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL b2b_unexpected got %h exp none", rx_data);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rx_data !== e) begin n_err++; $display("FAIL b2b_data #%0d got %h exp %h", got, rx_data, e); end
          end
          got++;
        end
      end
    join
    n_vec++; if (got !== N) begin n_err++; $display("FAIL b2b_count got %0d exp %0d (sent %0d)", got, N, sent_n); end
    repeat (BIT_CLK) @(negedge clk);
    rx_ready = 1'b0;
    loop = 1'b0;
  endtask

  task automatic test_parity();
    logic [7:0] d;
`ifdef SIO_PARITY_EN
    test_tx(8'h07);
    d = 8'h07;
    send_rx_frame(d, 1'b1, 1'b1, BIT_CLK);
    repeat (4) @(negedge clk);
    n_vec++; if (rx_parity_err !== 1'b1) begin n_err++; $display("FAIL parity_err got %b exp 1", rx_parity_err); end
`else
    d = 8'($urandom);
    send_rx_frame(d, 1'b1, 1'b0, BIT_CLK);
    repeat (4) @(negedge clk);
    n_vec++; if (rx_parity_err !== 1'b0) begin n_err++; $display("FAIL parity_err_tied got %b exp 0", rx_parity_err); end
`endif
    n_vec++; if (rx_valid !== 1'b1 || rx_data !== d) begin
      n_err++; $display("FAIL parity_data valid/data got %b/%h exp 1/%h", rx_valid, rx_data, d);
    end
    n_vec++; if (rx_frame_err !== 1'b0) begin n_err++; $display("FAIL parity_frame_err got %b exp 0", rx_frame_err); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    clear_errors();
  endtask

  task automatic test_reset_midframe();
    loop = 1'b0;
    rx_ready = 1'b0;
    send_rx_frame(8'($urandom), 1'b1, 1'b0, BIT_CLK);
    repeat (4) @(negedge clk);
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL midrst_fifo_loaded got %b exp 1", rx_valid); end
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (100) @(negedge clk);
    rx_drv = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++; if (tx_busy !== 1'b1 || rx_active !== 1'b1) begin
      n_err++; $display("FAIL midrst_inflight busy/active got %b%b exp 11", tx_busy, rx_active);
    end
    reset_n = 1'b0;
    #1;
    n_vec++; if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_tx tx/ready/busy got %b%b%b exp 110", tx, tx_ready, tx_busy);
    end
    n_vec++; if (rx_valid !== 1'b0 || rx_active !== 1'b0) begin
      n_err++; $display("FAIL midrst_rx valid/active got %b%b exp 00", rx_valid, rx_active);
    end
    rx_drv = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    n_vec++; if (rx_valid !== 1'b0 || rx_active !== 1'b0 || tx !== 1'b1) begin
      n_err++; $display("FAIL midrst_after valid/active/tx got %b%b%b exp 001", rx_valid, rx_active, tx);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    rx_drv   = 1'b1;
    loop     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_tx(8'h55);
    test_tx(8'($urandom));
    test_tx(8'($urandom));
    test_loopback(8'hA3);
    test_loopback(8'($urandom));
    test_loopback(8'($urandom));
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_parity();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
